// File: rtl/perf_pkg.sv
// Shared constants and helpers for the performance counter bank.
package perf_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Index width for n entries, never less than one bit so a single-channel bank still has a select line.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Shadow-register read port of the performance counter bank.
interface perf_counter_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    import perf_pkg::*;

    localparam int SEL_W = clog2_min1(NUM_CH);

    // rd_req has no ready: every request is accepted, and rd_valid pulses exactly one cycle later
    // carrying rd_data/rd_err for that request; requests may arrive every cycle.
    logic             rd_req;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             rd_err;

    modport master (output rd_req, rd_sel, input rd_valid, rd_data, rd_err);
    modport slave  (input rd_req, rd_sel, output rd_valid, rd_data, rd_err);

endinterface

// File: rtl/perf_counter_ch.sv
// One live event counter: clear beats increment, wrap or saturate on carry, sticky overflow.
module perf_counter_ch
    import perf_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int STEP_W   = 4,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              inc_en,
    input  logic [STEP_W-1:0] inc_step,
    input  logic              clr_en,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    logic [CNT_W:0] sum;

    // One extra bit so the carry out of the add is the overflow indication.
    assign sum = {1'b0, count} + {{(CNT_W + 1 - STEP_W){1'b0}}, inc_step};

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr_en) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (!freeze && inc_en) begin
            if (sum[CNT_W]) begin
                ovf   <= 1'b1;
                count <= (SATURATE == MODE_SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
            end else begin
                count <= sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Multi-channel event counter bank with a global snapshot into shadow registers and a registered read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int STEP_W   = 4,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     freeze,
    input  logic [NUM_CH-1:0]        inc_en,
    input  logic [NUM_CH*STEP_W-1:0] inc_step,
    input  logic [NUM_CH-1:0]        clr_en,
    input  logic                     snap_req,
    perf_counter_bank_if.slave       rd_bus,
    output logic [NUM_CH-1:0]        ovf
);

    logic [CNT_W-1:0] live   [NUM_CH];
    logic [CNT_W-1:0] shadow [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        perf_counter_ch #(
            .CNT_W   (CNT_W),
            .STEP_W  (STEP_W),
            .SATURATE(SATURATE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .freeze  (freeze),
            .inc_en  (inc_en[g]),
            .inc_step(inc_step[g*STEP_W +: STEP_W]),
            .clr_en  (clr_en[g]),
            .count   (live[g]),
            .ovf     (ovf[g])
        );
    end

    // Shadows capture the pre-edge live values, and a read in the same cycle as a snapshot
    // returns the previous shadow contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
            rd_bus.rd_valid <= 1'b0;
            rd_bus.rd_data  <= '0;
            rd_bus.rd_err   <= 1'b0;
        end else begin
            if (snap_req) begin
                for (int i = 0; i < NUM_CH; i++) shadow[i] <= live[i];
            end
            rd_bus.rd_valid <= rd_bus.rd_req;
            if (rd_bus.rd_req) begin
                if (int'(rd_bus.rd_sel) >= NUM_CH) begin
                    rd_bus.rd_data <= '0;
                    rd_bus.rd_err  <= 1'b1;
                end else begin
                    rd_bus.rd_data <= shadow[rd_bus.rd_sel];
                    rd_bus.rd_err  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: wrap, saturate and three-channel instances share one stimulus stream.
module tb_perf_counter_bank;
  import perf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [3:0]  inc_en;
  logic [15:0] inc_step;
  logic [3:0]  clr_en;
  logic        snap_req;
  logic        rd_req;
  logic [1:0]  rd_sel;
  logic [3:0]  ovf_w, ovf_s;
  logic [2:0]  ovf_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  perf_counter_bank_if #(.NUM_CH(4), .CNT_W(8)) if_w ();
  perf_counter_bank_if #(.NUM_CH(4), .CNT_W(8)) if_s ();
  perf_counter_bank_if #(.NUM_CH(3), .CNT_W(8)) if_t ();

  assign if_w.rd_req = rd_req;
  assign if_w.rd_sel = rd_sel;
  assign if_s.rd_req = rd_req;
  assign if_s.rd_sel = rd_sel;
  assign if_t.rd_req = rd_req;
  assign if_t.rd_sel = rd_sel;

  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .STEP_W(4), .SATURATE(MODE_WRAP)) u_wrap (
    .clk(clk), .rst(rst), .freeze(freeze), .inc_en(inc_en), .inc_step(inc_step),
    .clr_en(clr_en), .snap_req(snap_req), .rd_bus(if_w), .ovf(ovf_w));

  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .STEP_W(4), .SATURATE(MODE_SAT)) u_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .inc_en(inc_en), .inc_step(inc_step),
    .clr_en(clr_en), .snap_req(snap_req), .rd_bus(if_s), .ovf(ovf_s));

  perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .STEP_W(4), .SATURATE(MODE_WRAP)) u_three (
    .clk(clk), .rst(rst), .freeze(freeze), .inc_en(inc_en[2:0]), .inc_step(inc_step[11:0]),
    .clr_en(clr_en[2:0]), .snap_req(snap_req), .rd_bus(if_t), .ovf(ovf_t));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUT output views ----------------
  logic       dut_v   [3];
  logic [8:0] dut_ed  [3];
  logic [3:0] dut_ovf [3];
  assign dut_v[0]   = if_w.rd_valid;
  assign dut_v[1]   = if_s.rd_valid;
  assign dut_v[2]   = if_t.rd_valid;
  assign dut_ed[0]  = {if_w.rd_err, if_w.rd_data};
  assign dut_ed[1]  = {if_s.rd_err, if_s.rd_data};
  assign dut_ed[2]  = {if_t.rd_err, if_t.rd_data};
  assign dut_ovf[0] = ovf_w;
  assign dut_ovf[1] = ovf_s;
  assign dut_ovf[2] = {1'b0, ovf_t};

  // ---------------- reference model + scoreboard ----------------
  int         nch [3] = '{4, 4, 3};
  bit         sat [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] m_cnt [3][4];
  logic [7:0] m_sh  [3][4];
  logic [3:0] m_ovf [3];
  // One entry per read request: {err,data} of instance k at bits [k*9 +: 9].
  logic [26:0] exp_q[$];
  logic [26:0] last_e = '0;

  // Advance the model for the inputs currently driven, clock once, then score the outputs.
  task automatic cycle();
    logic [26:0] e;
    logic        exp_v;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_ovf[k] = '0;
        for (int c = 0; c < 4; c++) begin
          m_cnt[k][c] = '0;
          m_sh[k][c]  = '0;
        end
      end
      exp_q.delete();
      last_e = '0;
    end else begin
      if (rd_req) begin
        e = '0;
        for (int k = 0; k < 3; k++) begin
          if (int'(rd_sel) >= nch[k]) e[k*9 +: 9] = 9'h100;
          else e[k*9 +: 9] = {1'b0, m_sh[k][rd_sel]};
        end
        exp_q.push_back(e);
      end
      if (snap_req) begin
        for (int k = 0; k < 3; k++)
          for (int c = 0; c < nch[k]; c++) m_sh[k][c] = m_cnt[k][c];
      end
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < nch[k]; c++) begin
          int t;
          if (clr_en[c]) begin
            m_cnt[k][c] = '0;
            m_ovf[k][c] = 1'b0;
          end else if (!freeze && inc_en[c]) begin
            t = int'(m_cnt[k][c]) + int'(inc_step[c*4 +: 4]);
            if (t > 255) begin
              m_ovf[k][c] = 1'b1;
              m_cnt[k][c] = sat[k] ? 8'hFF : 8'(t - 256);
            end else begin
              m_cnt[k][c] = 8'(t);
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_v = (exp_q.size() != 0);
    if (exp_v) last_e = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (dut_v[k] !== exp_v)
        $display("FAIL sb_valid inst%0d cyc%0d got %b exp %b", k, cyc, dut_v[k], exp_v);
      else n_pass++;
      n_checks++;
      if (dut_ed[k] !== last_e[k*9 +: 9])
        $display("FAIL sb_data inst%0d cyc%0d got %h exp %h", k, cyc, dut_ed[k], last_e[k*9 +: 9]);
      else n_pass++;
      n_checks++;
      if (dut_ovf[k] !== m_ovf[k])
        $display("FAIL sb_ovf inst%0d cyc%0d got %h exp %h", k, cyc, dut_ovf[k], m_ovf[k]);
      else n_pass++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    freeze = 1'b0; inc_en = '0; inc_step = '0; clr_en = '0;
    snap_req = 1'b0; rd_req = 1'b0; rd_sel = '0;
  endtask

  task automatic clear_all();
    clr_en = 4'hF;
    cycle();
    clr_en = '0;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    cycle();
    snap_req = 1'b0;
  endtask

  // After return the read result is on the outputs.
  task automatic read_ch(input logic [1:0] sel);
    rd_req = 1'b1;
    rd_sel = sel;
    cycle();
    rd_req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; inc_en = 4'hF; inc_step = 16'h3333; rd_req = 1'b1; snap_req = 1'b1;
    repeat (4) cycle();
    n_checks++;
    if ({ovf_w, ovf_s, ovf_t} !== 11'h0) $display("FAIL reset_ovf got %h exp 0", {ovf_w, ovf_s, ovf_t});
    else n_pass++;
    n_checks++;
    if ({if_w.rd_valid, if_s.rd_valid, if_t.rd_valid} !== 3'b000)
      $display("FAIL reset_valid got %b exp 000", {if_w.rd_valid, if_s.rd_valid, if_t.rd_valid});
    else n_pass++;
    idle_inputs();
    rst = 1'b0;
    snap();
    read_ch(2'd0);
    n_checks++;
    if (if_w.rd_data !== 8'h00) $display("FAIL reset_count got %h exp 00", if_w.rd_data);
    else n_pass++;
  endtask

  task automatic test_wrap_sat();
    idle_inputs();
    clear_all();
    inc_en = 4'h1; inc_step = 16'h0001;
    repeat (254) cycle();
    inc_step = 16'h0005;
    cycle();
    inc_en = '0;
    snap();
    read_ch(2'd0);
    n_checks++;
    if (if_w.rd_data !== 8'h03) $display("FAIL wrap_count got %h exp 03", if_w.rd_data);
    else n_pass++;
    n_checks++;
    if (if_s.rd_data !== 8'hFF) $display("FAIL sat_count got %h exp ff", if_s.rd_data);
    else n_pass++;
    n_checks++;
    if ({ovf_w[0], ovf_s[0], ovf_t[0]} !== 3'b111) $display("FAIL ovf_set got %b exp 111", {ovf_w[0], ovf_s[0], ovf_t[0]});
    else n_pass++;
    inc_en = 4'h1; inc_step = 16'h0001;
    repeat (3) cycle();
    inc_en = '0;
    n_checks++;
    if (ovf_w[0] !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf_w[0]);
    else n_pass++;
    clr_en = 4'h1;
    cycle();
    clr_en = '0;
    n_checks++;
    if ({ovf_w[0], ovf_s[0]} !== 2'b00) $display("FAIL ovf_clear got %b exp 00", {ovf_w[0], ovf_s[0]});
    else n_pass++;
    snap();
    read_ch(2'd0);
    n_checks++;
    if (if_s.rd_data !== 8'h00) $display("FAIL sat_clear_count got %h exp 00", if_s.rd_data);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    clear_all();
    inc_en = 4'h2; inc_step = 16'h00A0;
    cycle();
    clr_en = 4'h2; inc_step = 16'h0020; snap_req = 1'b1;
    cycle();
    idle_inputs();
    read_ch(2'd1);
    n_checks++;
    if (if_w.rd_data !== 8'd10) $display("FAIL simul_shadow got %0d exp 10", if_w.rd_data);
    else n_pass++;
    snap();
    read_ch(2'd1);
    n_checks++;
    if (if_t.rd_data !== 8'd0) $display("FAIL simul_live got %0d exp 0", if_t.rd_data);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    clear_all();
    inc_en = 4'hD; inc_step = 16'h3C07;
    cycle();
    idle_inputs();
    snap();
    rd_req = 1'b1; rd_sel = 2'd2;
    cycle();
    n_checks++;
    if ({if_w.rd_valid, if_w.rd_data} !== {1'b1, 8'd12}) $display("FAIL b2b_first got %b/%0d exp 1/12", if_w.rd_valid, if_w.rd_data);
    else n_pass++;
    rd_sel = 2'd3;
    cycle();
    rd_req = 1'b0;
    n_checks++;
    if ({if_w.rd_valid, if_w.rd_data} !== {1'b1, 8'd3}) $display("FAIL b2b_second got %b/%0d exp 1/3", if_w.rd_valid, if_w.rd_data);
    else n_pass++;
    n_checks++;
    if ({if_t.rd_valid, if_t.rd_err, if_t.rd_data} !== {2'b11, 8'd0})
      $display("FAIL bad_index got %b/%b/%0d exp 1/1/0", if_t.rd_valid, if_t.rd_err, if_t.rd_data);
    else n_pass++;
    cycle();
    n_checks++;
    if ({if_w.rd_valid, if_w.rd_data} !== {1'b0, 8'd3}) $display("FAIL rd_hold got %b/%0d exp 0/3", if_w.rd_valid, if_w.rd_data);
    else n_pass++;
  endtask

  task automatic test_freeze();
    idle_inputs();
    freeze = 1'b1; inc_en = 4'hF; inc_step = 16'hFFFF;
    repeat (3) cycle();
    clr_en = 4'h1;
    cycle();
    idle_inputs();
    snap();
    read_ch(2'd2);
    n_checks++;
    if (if_w.rd_data !== 8'd12) $display("FAIL freeze_hold got %0d exp 12", if_w.rd_data);
    else n_pass++;
    read_ch(2'd0);
    n_checks++;
    if (if_w.rd_data !== 8'd0) $display("FAIL freeze_clr got %0d exp 0", if_w.rd_data);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      freeze   = ($urandom_range(0, 7) == 0);
      inc_en   = 4'($urandom_range(0, 15));
      inc_step = 16'($urandom_range(0, 65535));
      clr_en   = '0;
      for (int c = 0; c < 4; c++) clr_en[c] = ($urandom_range(0, 15) == 0);
      snap_req = ($urandom_range(0, 7) == 0);
      rd_req   = ($urandom_range(0, 1) == 1);
      rd_sel   = 2'($urandom_range(0, 3));
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_wrap_sat();
    test_simultaneous();
    test_back_to_back();
    test_freeze();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
